// File: rtl/mac_seq_pkg.sv
// Shared state encoding and Q6.9 constants
// for the MAC operand sequencer.
package mac_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    RESULT
  } state_e;

  localparam logic [15:0] Q_ONE = 16'h0200;
  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8001;

endpackage

// File: rtl/mac_tap_store.sv
// Sample history shift register plus
// coefficient bank with one indexed read port.
module mac_tap_store
  import mac_seq_pkg::*;
#(
  parameter int TAPS   = 8,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n_i,
  input  logic                    shift_i,
  input  logic [DATA_W-1:0]       sample_i,
  input  logic                    we_i,
  input  logic [$clog2(TAPS)-1:0] waddr_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic [$clog2(TAPS)-1:0] raddr_i,
  output logic [DATA_W-1:0]       hist_o,
  output logic [DATA_W-1:0]       coef_o
);

  logic [DATA_W-1:0] hist_q [TAPS];
  logic [DATA_W-1:0] coef_q [TAPS];

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      if (shift_i) begin
        hist_q[0] <= sample_i;
        for (int i = 1; i < TAPS; i++) begin
          hist_q[i] <= hist_q[i-1];
        end
      end
      if (we_i) begin
        coef_q[waddr_i] <= wdata_i;
      end
    end
  end

  assign hist_o = hist_q[raddr_i];
  assign coef_o = coef_q[raddr_i];

endmodule

// File: rtl/mac_tap_sequencer.sv
// Streams TAPS (sample, coef) pairs into the MAC
// per accepted sample and returns the accumulated result.
module mac_tap_sequencer
  import mac_seq_pkg::*;
#(
  parameter int TAPS    = 8,
  parameter int DATA_W  = 16,
  parameter int MAC_LAT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  input  logic                      coef_we,
  // one spare code point so out-of-range indices are expressible
  input  logic [$clog2(TAPS+1)-1:0] coef_addr,
  input  logic [DATA_W-1:0]         coef_data,
  output logic                      coef_err,
  output logic                      mac_clr_n,
  output logic [DATA_W-1:0]         mac_a,
  output logic [DATA_W-1:0]         mac_b,
  input  logic [DATA_W-1:0]         mac_result,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready
);

  localparam int KW = $clog2(TAPS);
  localparam int AW = $clog2(TAPS+1);
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(TAPS-1);
  localparam logic [DW-1:0] D_LAST = DW'(MAC_LAT-1);

  state_e            state_q;
  logic [KW-1:0]     k_q;
  logic [DW-1:0]     d_q;
  logic              in_ready_q;
  logic              mac_clr_n_q;
  logic [DATA_W-1:0] mac_a_q;
  logic [DATA_W-1:0] mac_b_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              coef_err_q;

  logic              accept;
  logic              coef_ok;
  logic [KW-1:0]     rd_idx;
  logic [DATA_W-1:0] hist_rd;
  logic [DATA_W-1:0] coef_rd;

  assign accept  = (state_q == IDLE) && in_ready_q && in_valid;
  assign coef_ok = (state_q == IDLE) && (coef_addr < AW'(TAPS));
  // read one tap ahead so the registered operands line up with k_q
  assign rd_idx  = (state_q == FEED && k_q != K_LAST) ?
                   k_q + KW'(1) : '0;

  mac_tap_store #(
    .TAPS   (TAPS),
    .DATA_W (DATA_W)
  ) u_store (
    .clk      (clk),
    .rst_n_i  (reset),
    .shift_i  (accept),
    .sample_i (in_data),
    .we_i     (coef_we && coef_ok),
    .waddr_i  (coef_addr[KW-1:0]),
    .wdata_i  (coef_data),
    .raddr_i  (rd_idx),
    .hist_o   (hist_rd),
    .coef_o   (coef_rd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      d_q         <= '0;
      in_ready_q  <= 1'b0;
      mac_clr_n_q <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      coef_err_q  <= 1'b0;
    end else begin
      if (coef_we && !coef_ok) begin
        coef_err_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= CLEAR;
            in_ready_q  <= 1'b0;
            mac_clr_n_q <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
          end else begin
            in_ready_q  <= 1'b1;
            mac_clr_n_q <= 1'b1;
          end
        end
        CLEAR: begin
          state_q     <= FEED;
          k_q         <= '0;
          mac_clr_n_q <= 1'b1;
          mac_a_q     <= hist_rd;
          mac_b_q     <= coef_rd;
        end
        FEED: begin
          if (k_q == K_LAST) begin
            state_q <= DRAIN;
            d_q     <= '0;
            mac_a_q <= '0;
            mac_b_q <= '0;
          end else begin
            k_q     <= k_q + KW'(1);
            mac_a_q <= hist_rd;
            mac_b_q <= coef_rd;
          end
        end
        DRAIN: begin
          if (d_q == D_LAST) begin
            state_q     <= RESULT;
            out_valid_q <= 1'b1;
            out_data_q  <= mac_result;
          end else begin
            d_q <= d_q + DW'(1);
          end
        end
        RESULT: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mac_clr_n = mac_clr_n_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_mac_tap_sequencer.sv
// Scoreboard bench: sequencer driving a behavioural
// saturating Q6.9 MAC with a 4-cycle pipeline.
module tb_mac_tap_sequencer;
  import mac_seq_pkg::*;

  localparam int TAPS    = 8;
  localparam int MAC_LAT = 4;

  typedef struct packed {
    logic [TAPS-1:0][15:0] a;
    logic [TAPS-1:0][15:0] b;
    logic [15:0]           res;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic        coef_err;
  logic        mac_clr_n;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [15:0] mac_result;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b1;

  int     n_chk = 0;
  int     n_err = 0;
  bit     act = 0;
  bit     rnd_ordy = 0;
  frame_t exp_q [$];
  logic [15:0] hist_m [TAPS];
  logic [15:0] coef_m [TAPS];

  mac_tap_sequencer #(
    .TAPS    (TAPS),
    .DATA_W  (16),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_err   (coef_err),
    .mac_clr_n  (mac_clr_n),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_result (mac_result),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [15:0] sat16(input longint v);
    longint hi;
    longint lo;
    hi = longint'($signed(Q_MAX));
    lo = longint'($signed(Q_MIN));
    if (v > hi) return Q_MAX;
    if (v < lo) return Q_MIN;
    return v[15:0];
  endfunction

  function automatic logic [15:0] q_mul(input logic [15:0] a,
                                        input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return sat16((p + 256) >>> 9);
  endfunction

  function automatic logic [15:0] q_add(input logic [15:0] a,
                                        input logic [15:0] b);
    return sat16(longint'($signed(a)) + longint'($signed(b)));
  endfunction

  // MAC environment: product, two pipe stages, accumulator
  logic [15:0] p1, p2, p3, acc;
  always_ff @(posedge clk) begin
    if (!mac_clr_n) begin
      p1  <= '0;
      p2  <= '0;
      p3  <= '0;
      acc <= '0;
    end else begin
      p1  <= q_mul(mac_a, mac_b);
      p2  <= p1;
      p3  <= p2;
      acc <= q_add(acc, p3);
    end
  end
  assign mac_result = acc;

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, a, e, $time);
    end
  endtask

  initial begin : monitor
    frame_t      cur;
    int          rel;
    int          k;
    logic [15:0] held;
    cur  = '0;
    rel  = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        act = 0;
        exp_q.delete();
      end else if (act) begin
        rel++;
        if (rel == 1) begin
          if (exp_q.size() == 0) begin
            chk(0, "no_expect", 64'd0, 64'd1);
            act = 0;
          end else begin
            cur = exp_q.pop_front();
            chk(mac_clr_n === 1'b0 && mac_a === '0 && mac_b === '0,
                "clear", {mac_clr_n, mac_a, mac_b}, 64'd0);
          end
        end else if (rel <= TAPS + 1) begin
          k = rel - 2;
          chk(mac_clr_n === 1'b1 && mac_a === cur.a[k] &&
              mac_b === cur.b[k], "feed",
              {mac_clr_n, mac_a, mac_b}, {1'b1, cur.a[k], cur.b[k]});
        end else if (rel <= TAPS + MAC_LAT + 1) begin
          chk(mac_a === '0 && mac_b === '0 && out_valid === 1'b0,
              "drain", {out_valid, mac_a, mac_b}, 64'd0);
        end else begin
          if (rel == TAPS + MAC_LAT + 2) begin
            chk(out_valid === 1'b1, "latency", out_valid, 64'd1);
            chk(out_data === cur.res, "result", out_data, cur.res);
            held = out_data;
          end else begin
            chk(out_valid === 1'b1 && out_data === held, "hold",
                {out_valid, out_data}, {1'b1, held});
          end
          chk(in_ready === 1'b0, "busy_ready", in_ready, 64'd0);
          if (out_valid && out_ready) act = 0;
        end
      end else if (in_valid && in_ready) begin
        act = 1;
        rel = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ordy) out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic send(input logic [15:0] x, input bit we = 0,
                      input logic [3:0] wa = '0,
                      input logic [15:0] wd = '0);
    frame_t f;
    bit     got;
    got       = 0;
    in_valid  = 1'b1;
    in_data   = x;
    coef_we   = we;
    coef_addr = wa;
    coef_data = wd;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk(0, "accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      coef_we  = 1'b0;
      return;
    end
    if (we && wa < TAPS) coef_m[wa[2:0]] = wd;
    for (int i = TAPS - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
    hist_m[0] = x;
    f = '0;
    for (int i = 0; i < TAPS; i++) begin
      f.a[i] = hist_m[i];
      f.b[i] = coef_m[i];
      f.res  = q_add(f.res, q_mul(hist_m[i], coef_m[i]));
    end
    exp_q.push_back(f);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      if (!act && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(0, "done_timeout", 64'd0, 64'd1);
    #1;
  endtask

  task automatic wr_coef(input logic [3:0] a, input logic [15:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    if (a < TAPS) coef_m[a[2:0]] = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk({in_ready, mac_clr_n, out_valid, coef_err,
         mac_a, mac_b, out_data} === 52'h0, "reset_out",
        {in_ready, mac_clr_n, out_valid, coef_err,
         mac_a, mac_b, out_data}, 64'd0);
    reset = 1'b1;
    for (int i = 0; i < TAPS; i++) begin
      hist_m[i] = '0;
      coef_m[i] = '0;
    end
    @(posedge clk);
    #1;
    chk(in_ready === 1'b1, "ready_after_reset", in_ready, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s;
    #2;
    do_reset();

    for (int i = 0; i < TAPS; i++) wr_coef(4'(i), Q_ONE);
    send(Q_ONE);
    wait_done();
    send(16'h0400);
    wait_done();

    wr_coef(4'd8, 16'h5555);
    chk(coef_err === 1'b1, "err_addr", coef_err, 64'd1);
    send(16'h0000);
    wait_done();

    for (int i = 0; i < TAPS; i++) wr_coef(4'(i), Q_MAX);
    repeat (TAPS) send(Q_MAX);
    wait_done();
    repeat (TAPS) send(Q_MIN);
    wait_done();

    out_ready = 1'b0;
    send(16'h0100);
    in_valid = 1'b1;
    in_data  = 16'h0300;
    repeat (TAPS + MAC_LAT + 22) @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'h0300);
    wait_done();

    send(16'h0123);
    repeat (4) @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < TAPS; i++) wr_coef(4'(i), 16'($urandom));
    send(16'h0280);
    wait_done();

    send(16'h0040);
    repeat (3) @(posedge clk);
    #1;
    coef_we   = 1'b1;
    coef_addr = 4'd2;
    coef_data = 16'h1234;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    chk(coef_err === 1'b1, "err_busy", coef_err, 64'd1);
    wait_done();
    send(16'h0010);
    wait_done();

    rnd_ordy = 1;
    repeat (30) begin
      if ($urandom_range(0, 1) == 0) s = 16'($urandom);
      else s = 16'($urandom_range(0, 1023)) - 16'd512;
      if ($urandom_range(0, 3) == 0) begin
        wait_done();
        wr_coef(4'($urandom_range(0, 7)), 16'($urandom));
      end
      if ($urandom_range(0, 4) == 0) begin
        wait_done();
        send(s, 1'b1, 4'($urandom_range(0, 7)), 16'($urandom));
      end else begin
        send(s);
      end
    end
    wait_done();
    rnd_ordy = 0;
    chk(coef_err === 1'b1, "err_sticky", coef_err, 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
